// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: RV32I funct3 codes,
// FSM state encoding and access-size decode.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_REQ_ENC    = 2'd1;
    localparam logic [1:0] ST_WAIT_R_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE_ENC,
        REQ    = ST_REQ_ENC,
        WAIT_R = ST_WAIT_R_ENC
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Encodings 011 and 11x fall through to word.
    function automatic logic [1:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byte enables / replicated write data
// and load lane extraction with sign or zero extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_ext
);

    logic [1:0]         size;
    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    assign size = size_of(funct3);

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = load_data[7:0];
            2'd1:    byte_sel = load_data[15:8];
            2'd2:    byte_sel = load_data[23:16];
            default: byte_sel = load_data[31:24];
        endcase
        half_sel = addr_lo[1] ? load_data[31:16] : load_data[15:0];
    end

    always_comb begin
        be       = 4'b1111;
        wdata    = store_data;
        load_ext = load_data;
        case (size)
            SZ_BYTE: begin
                be       = 4'b0001 << addr_lo;
                wdata    = {4{store_data[7:0]}};
                load_ext = funct3[2] ? {24'd0, byte_sel} : 32'(byte_sel);
            end
            SZ_HALF: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{store_data[15:0]}};
                load_ext = funct3[2] ? {16'd0, half_sel} : 32'(half_sel);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_mem_access.sv
// Memory-access stage: runs loads/stores on a req/gnt/rvalid bus, one wb pulse per instruction.
// Optional macro MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of masking.
module instr_mem_access
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ctrl_memread,
    input  logic              ctrl_memwrite,
    input  logic [2:0]        funct3,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       regs_rdata2,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_be,
    output logic [31:0]       dbus_wdata,
    input  logic              dbus_gnt,
    input  logic              dbus_rvalid,
    input  logic [31:0]       dbus_rdata,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic              misalign
);

    state_t      state;
    logic [2:0]  f3_q;
    logic [1:0]  alo_q;
    logic        is_mem;
    logic        mis_trap;
    logic [2:0]  lane_f3;
    logic [1:0]  lane_alo;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;

    assign is_mem = ctrl_memread | ctrl_memwrite;

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        mis_trap = 1'b0;
        if (is_mem) begin
            case (size_of(funct3))
                SZ_HALF: mis_trap = alu_result[0];
                SZ_WORD: mis_trap = |alu_result[1:0];
                default: mis_trap = 1'b0;
            endcase
        end
    end
`else
    assign mis_trap = 1'b0;
`endif

    // One aligner serves both directions: live inputs at capture, latched copies for load return.
    assign lane_f3  = (state == IDLE) ? funct3 : f3_q;
    assign lane_alo = (state == IDLE) ? alu_result[1:0] : alo_q;

    mem_lane_align u_align (
        .funct3     (lane_f3),
        .addr_lo    (lane_alo),
        .store_data (regs_rdata2),
        .load_data  (dbus_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_ext   (lane_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ex_ready   <= 1'b1;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_be    <= 4'd0;
            dbus_wdata <= 32'd0;
            wb_valid   <= 1'b0;
            wb_data    <= 32'd0;
            misalign   <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        f3_q  <= funct3;
                        alo_q <= alu_result[1:0];
                        if (is_mem && !mis_trap) begin
                            state      <= REQ;
                            ex_ready   <= 1'b0;
                            dbus_req   <= 1'b1;
                            dbus_we    <= ctrl_memwrite;
                            dbus_addr  <= {alu_result[ADDR_W-1:2], 2'b00};
                            dbus_be    <= lane_be;
                            dbus_wdata <= lane_wdata;
                        end else begin
                            wb_valid <= 1'b1;
                            wb_data  <= alu_result;
                            misalign <= mis_trap;
                        end
                    end
                end
                REQ: begin
                    if (dbus_gnt) begin
                        dbus_req <= 1'b0;
                        if (dbus_we) begin
                            state    <= IDLE;
                            ex_ready <= 1'b1;
                            wb_valid <= 1'b1;
                            wb_data  <= 32'd0;
                        end else begin
                            state <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (dbus_rvalid) begin
                        state    <= IDLE;
                        ex_ready <= 1'b1;
                        wb_valid <= 1'b1;
                        wb_data  <= lane_load;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ex_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_access.sv
// Directed-vector bench for instr_mem_access: table of load/store transactions
// plus hand sequences for pass-through, stray bus events, reset and misalignment.
module tb_instr_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic        ctrl_memread;
    logic        ctrl_memwrite;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] regs_rdata2;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        misalign;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_mem_access #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ctrl_memread  (ctrl_memread),
        .ctrl_memwrite (ctrl_memwrite),
        .funct3        (funct3),
        .alu_result    (alu_result),
        .regs_rdata2   (regs_rdata2),
        .dbus_req      (dbus_req),
        .dbus_we       (dbus_we),
        .dbus_addr     (dbus_addr),
        .dbus_be       (dbus_be),
        .dbus_wdata    (dbus_wdata),
        .dbus_gnt      (dbus_gnt),
        .dbus_rvalid   (dbus_rvalid),
        .dbus_rdata    (dbus_rdata),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .misalign      (misalign)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rdata2;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] exp_addr;
        logic [31:0] wdata;
        logic [31:0] wb;
    } vec_t;

    vec_t vecs [0:11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_mem(input vec_t v, input int gnt_dly, input int rv_dly);
        ex_valid      = 1'b1;
        ctrl_memread  = v.rd;
        ctrl_memwrite = v.wr;
        funct3        = v.f3;
        alu_result    = v.addr;
        regs_rdata2   = v.rdata2;
        tick();
        // Scramble inputs so only the latched copies can produce correct results.
        ex_valid      = 1'b0;
        funct3        = ~v.f3;
        alu_result    = 32'hFFFF_FFFF;
        regs_rdata2   = 32'h0;
        chk("req_issued", 32'(dbus_req), 32'd1);
        chk("ex_ready_busy", 32'(ex_ready), 32'd0);
        chk("dbus_we", 32'(dbus_we), 32'(v.wr));
        chk("dbus_addr", dbus_addr, v.exp_addr);
        chk("dbus_be", 32'(dbus_be), 32'(v.be));
        chk("dbus_wdata", dbus_wdata, v.wdata);
        for (int i = 0; i < gnt_dly; i++) begin
            tick();
            chk("req_hold", 32'(dbus_req), 32'd1);
            chk("addr_hold", dbus_addr, v.exp_addr);
            chk("be_hold", 32'(dbus_be), 32'(v.be));
            chk("wdata_hold", dbus_wdata, v.wdata);
            chk("ex_ready_wait", 32'(ex_ready), 32'd0);
        end
        dbus_gnt = 1'b1;
        if (!v.wr) begin
            dbus_rvalid = 1'b1;
            dbus_rdata  = ~v.rdata;
        end
        tick();
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b0;
        chk("req_drop", 32'(dbus_req), 32'd0);
        if (v.wr) begin
            chk("store_wb_valid", 32'(wb_valid), 32'd1);
            chk("store_wb_data", wb_data, 32'd0);
            chk("store_misalign", 32'(misalign), 32'd0);
            chk("store_ex_ready", 32'(ex_ready), 32'd1);
        end else begin
            chk("no_same_cycle_rvalid", 32'(wb_valid), 32'd0);
            for (int i = 0; i < rv_dly; i++) begin
                tick();
                chk("wait_no_wb", 32'(wb_valid), 32'd0);
                chk("wait_ex_ready", 32'(ex_ready), 32'd0);
            end
            dbus_rvalid = 1'b1;
            dbus_rdata  = v.rdata;
            tick();
            dbus_rvalid = 1'b0;
            dbus_rdata  = 32'h0;
            chk("load_wb_valid", 32'(wb_valid), 32'd1);
            chk("load_wb_data", wb_data, v.wb);
            chk("load_misalign", 32'(misalign), 32'd0);
            chk("load_ex_ready", 32'(ex_ready), 32'd1);
        end
        tick();
        chk("wb_single_pulse", 32'(wb_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //            rd    wr    f3      addr          rdata2        rdata         be       exp_addr      wdata         wb
        vecs[0]  = '{1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 32'h0,        4'b1000, 32'h0000_1000, 32'hDDDD_DDDD, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 3'b001, 32'h0000_1002, 32'hAABB_CCDD, 32'h0,        4'b1100, 32'h0000_1000, 32'hCCDD_CCDD, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 3'b010, 32'h0000_1004, 32'h1122_3344, 32'h0,        4'b1111, 32'h0000_1004, 32'h1122_3344, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'h0,         32'h0000_8000, 4'b0010, 32'h0000_2000, 32'h0,         32'hFFFF_FF80};
        vecs[4]  = '{1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'h0,         32'h0000_8000, 4'b0010, 32'h0000_2000, 32'h0,         32'h0000_0080};
        vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0,         32'h8001_0000, 4'b1100, 32'h0000_2000, 32'h0,         32'hFFFF_8001};
        vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0,         32'h8001_0000, 4'b1100, 32'h0000_2000, 32'h0,         32'h0000_8001};
        vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h0000_2008, 32'h0,         32'hDEAD_BEEF, 4'b1111, 32'h0000_2008, 32'h0,         32'hDEAD_BEEF};
        vecs[8]  = '{1'b1, 1'b0, 3'b000, 32'h0000_2003, 32'h0,         32'h7F00_0000, 4'b1000, 32'h0000_2000, 32'h0,         32'h0000_007F};
        vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h0000_200C, 32'h0,         32'h1234_5678, 4'b1111, 32'h0000_200C, 32'h0,         32'h1234_5678};
        vecs[10] = '{1'b1, 1'b0, 3'b110, 32'h0000_2010, 32'h0,         32'hCAFE_BABE, 4'b1111, 32'h0000_2010, 32'h0,         32'hCAFE_BABE};
        vecs[11] = '{1'b1, 1'b1, 3'b010, 32'h0000_3000, 32'h55AA_55AA, 32'h0,        4'b1111, 32'h0000_3000, 32'h55AA_55AA, 32'h0};

        rst = 1'b1; ex_valid = 1'b0; ctrl_memread = 1'b0; ctrl_memwrite = 1'b0;
        funct3 = 3'b0; alu_result = 32'h0; regs_rdata2 = 32'h0;
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'h0;
        tick();
        tick();
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_dbus_req", 32'(dbus_req), 32'd0);
        chk("rst_dbus_we", 32'(dbus_we), 32'd0);
        chk("rst_dbus_addr", dbus_addr, 32'd0);
        chk("rst_dbus_be", 32'(dbus_be), 32'd0);
        chk("rst_dbus_wdata", dbus_wdata, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        rst = 1'b0;

        // Back-to-back ALU pass-through, one result per cycle.
        ex_valid = 1'b1; alu_result = 32'h1234_5678;
        tick();
        chk("pass1_wb_valid", 32'(wb_valid), 32'd1);
        chk("pass1_wb_data", wb_data, 32'h1234_5678);
        chk("pass1_no_req", 32'(dbus_req), 32'd0);
        chk("pass1_ex_ready", 32'(ex_ready), 32'd1);
        alu_result = 32'h9ABC_DEF0;
        tick();
        ex_valid = 1'b0;
        chk("pass2_wb_valid", 32'(wb_valid), 32'd1);
        chk("pass2_wb_data", wb_data, 32'h9ABC_DEF0);
        tick();
        chk("pass_end_wb_valid", 32'(wb_valid), 32'd0);

        for (int i = 0; i < 12; i++)
            run_mem(vecs[i], (i == 0) ? 2 : i % 3, i % 2);

        // Stray gnt/rvalid in IDLE, then a load whose data arrives late.
        dbus_gnt = 1'b1; dbus_rvalid = 1'b1; dbus_rdata = 32'h1111_1111;
        tick();
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
        chk("stray_no_wb", 32'(wb_valid), 32'd0);
        chk("stray_no_req", 32'(dbus_req), 32'd0);
        v = '{1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'hA5A5_5A5A, 4'b1111, 32'h0000_4000, 32'h0, 32'hA5A5_5A5A};
        run_mem(v, 0, 3);

        // Reset while waiting for read data; the late rvalid must be dropped.
        ex_valid = 1'b1; ctrl_memread = 1'b1; ctrl_memwrite = 1'b0;
        funct3 = 3'b010; alu_result = 32'h0000_5000;
        tick();
        ex_valid = 1'b0;
        dbus_gnt = 1'b1;
        tick();
        dbus_gnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_req", 32'(dbus_req), 32'd0);
        chk("rstmid_ex_ready", 32'(ex_ready), 32'd1);
        chk("rstmid_wb_valid", 32'(wb_valid), 32'd0);
        dbus_rvalid = 1'b1; dbus_rdata = 32'hBEEF_0001;
        tick();
        dbus_rvalid = 1'b0;
        chk("late_rvalid_no_wb", 32'(wb_valid), 32'd0);
        tick();
        chk("late_rvalid_no_wb2", 32'(wb_valid), 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
        ex_valid = 1'b1; ctrl_memread = 1'b1; ctrl_memwrite = 1'b0;
        funct3 = 3'b010; alu_result = 32'h0000_3002;
        tick();
        ex_valid = 1'b0;
        chk("trap_no_req", 32'(dbus_req), 32'd0);
        chk("trap_wb_valid", 32'(wb_valid), 32'd1);
        chk("trap_misalign", 32'(misalign), 32'd1);
        chk("trap_wb_data", wb_data, 32'h0000_3002);
        chk("trap_ex_ready", 32'(ex_ready), 32'd1);
        tick();
        chk("trap_pulse", 32'(wb_valid), 32'd0);
        chk("trap_misalign_clr", 32'(misalign), 32'd0);
`else
        v = '{1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0, 32'h0BAD_F00D, 4'b1111, 32'h0000_3000, 32'h0, 32'h0BAD_F00D};
        run_mem(v, 1, 0);
        v = '{1'b1, 1'b0, 3'b001, 32'h0000_2003, 32'h0, 32'h8001_0000, 4'b1100, 32'h0000_2000, 32'h0, 32'hFFFF_8001};
        run_mem(v, 0, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
